// File: rtl/comm_pkg.sv
// Shared types for the comm_slave command link: receive/transmit FSM states and frame length.
package comm_pkg;

   localparam int FRAME_BYTES = 3;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_WAIT_M,
      RX_WAIT_L
   } rx_state_t;

   typedef enum logic {
      TX_IDLE,
      TX_BUSY
   } tx_state_t;

endpackage

// File: rtl/uart_trx.sv
// Byte-level 8N1 UART transceiver, LSB first; rx_rdy holds until clr_rx_rdy, tx_done pulses
// for one clock when the stop bit has fully left TX.
module uart_trx #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   output logic       TX,
   output logic       rx_rdy,
   input  logic       clr_rx_rdy,
   output logic [7:0] rx_data,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done
);

   localparam int            BW     = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] L_FULL = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] L_HALF = BW'(BAUD_DIV / 2 - 1);

   logic          r_rx_s1, r_rx_s2, r_rx_prev;
   logic          r_rx_busy, r_rx_rdy;
   logic [BW-1:0] r_rx_baud;
   logic [3:0]    r_rx_bit;
   logic [7:0]    r_rx_shift, r_rx_data;
   logic          w_rx_fall, w_rx_tick;

   logic          r_tx, r_tx_busy, r_tx_done;
   logic [BW-1:0] r_tx_baud;
   logic [3:0]    r_tx_bit;
   logic [7:0]    r_tx_shift;

   assign w_rx_fall = r_rx_prev & ~r_rx_s2;
   // Half a bit to reach mid-start, then a full bit between every later sample.
   assign w_rx_tick = (r_rx_baud == ((r_rx_bit == 4'd0) ? L_HALF : L_FULL));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
         r_rx_busy <= 1'b0;
         r_rx_rdy  <= 1'b0;
         r_rx_baud <= '0;
         r_rx_bit  <= '0;
      end else begin
         r_rx_s1   <= RX;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
         if (clr_rx_rdy) r_rx_rdy <= 1'b0;
         if (!r_rx_busy) begin
            if (w_rx_fall) r_rx_busy <= 1'b1;
            r_rx_baud <= '0;
            r_rx_bit  <= '0;
         end else if (w_rx_tick) begin
            r_rx_baud <= '0;
            if (r_rx_bit == 4'd0) begin
               if (r_rx_s2) r_rx_busy <= 1'b0;
               else         r_rx_bit  <= 4'd1;
            end else if (r_rx_bit <= 4'd8) begin
               r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
               r_rx_bit   <= r_rx_bit + 4'd1;
            end else begin
               r_rx_busy <= 1'b0;
               if (r_rx_s2) begin
                  r_rx_data <= r_rx_shift;
                  r_rx_rdy  <= 1'b1;
               end
            end
         end else begin
            r_rx_baud <= r_rx_baud + BW'(1);
         end
      end
   end

   // r_tx_bit counts completed bit periods: 0 = start, 1..8 = data, 9 = stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx      <= 1'b1;
         r_tx_busy <= 1'b0;
         r_tx_done <= 1'b0;
         r_tx_baud <= '0;
         r_tx_bit  <= '0;
      end else begin
         r_tx_done <= 1'b0;
         if (!r_tx_busy) begin
            if (trmt) begin
               r_tx_shift <= tx_data;
               r_tx       <= 1'b0;
               r_tx_busy  <= 1'b1;
               r_tx_baud  <= '0;
               r_tx_bit   <= '0;
            end
         end else if (r_tx_baud == L_FULL) begin
            r_tx_baud <= '0;
            r_tx_bit  <= r_tx_bit + 4'd1;
            if (r_tx_bit < 4'd8) begin
               r_tx       <= r_tx_shift[0];
               r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end else if (r_tx_bit == 4'd8) begin
               r_tx <= 1'b1;
            end else begin
               r_tx_busy <= 1'b0;
               r_tx_done <= 1'b1;
            end
         end else begin
            r_tx_baud <= r_tx_baud + BW'(1);
         end
      end
   end

   assign TX      = r_tx;
   assign tx_done = r_tx_done;
   assign rx_rdy  = r_rx_rdy;
   assign rx_data = r_rx_data;

endmodule

// File: rtl/comm_slave.sv
// Responder end of the 3-byte UART command link (cmd, data hi, data lo) with a 1-byte response.
// Optional inter-byte timeout enabled by defining COMM_SLAVE_TIMEOUT_EN.
import comm_pkg::*;

module comm_slave #(
   parameter int BAUD_DIV    = 2604,
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        snd_resp,
   output logic        resp_sent,
   output logic        frm_err
);

   rx_state_t   r_rx_state;
   tx_state_t   r_tx_state;
   logic [7:0]  r_cmd_s, r_hi_s, r_cmd;
   logic [15:0] r_data;
   logic        r_cmd_rdy, r_resp_sent;
   logic        w_rx_rdy, w_tx_done, w_trmt, w_to_expire;
   logic [7:0]  w_rx_byte;

   // Each byte is consumed the cycle it is flagged, so rx_rdy doubles as its own clear.
   assign w_trmt = snd_resp && (r_tx_state == TX_IDLE);

   uart_trx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_trx (
      .clk        (clk),
      .rst        (rst),
      .RX         (RX),
      .TX         (TX),
      .rx_rdy     (w_rx_rdy),
      .clr_rx_rdy (w_rx_rdy),
      .rx_data    (w_rx_byte),
      .trmt       (w_trmt),
      .tx_data    (resp),
      .tx_done    (w_tx_done)
   );

`ifdef COMM_SLAVE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_frm_err;

   assign w_to_expire = (r_rx_state != RX_IDLE) && !w_rx_rdy &&
                        (r_to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_to_cnt  <= '0;
         r_frm_err <= 1'b0;
      end else begin
         r_frm_err <= w_to_expire;
         if ((r_rx_state == RX_IDLE) || w_rx_rdy || w_to_expire) r_to_cnt <= '0;
         else                                                    r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   assign frm_err = r_frm_err;
`else
   // No timeout: a partial frame waits forever and frm_err never fires.
   assign w_to_expire = 1'b0;
   assign frm_err     = (TIMEOUT_CYC < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
         r_cmd      <= '0;
         r_data     <= '0;
         r_cmd_rdy  <= 1'b0;
      end else begin
         if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
         case (r_rx_state)
            RX_IDLE:
               if (w_rx_rdy) begin
                  r_cmd_s    <= w_rx_byte;
                  r_rx_state <= RX_WAIT_M;
               end
            RX_WAIT_M:
               if (w_rx_rdy) begin
                  r_hi_s     <= w_rx_byte;
                  r_rx_state <= RX_WAIT_L;
               end
            RX_WAIT_L:
               if (w_rx_rdy) begin
                  r_cmd      <= r_cmd_s;
                  r_data     <= {r_hi_s, w_rx_byte};
                  r_cmd_rdy  <= 1'b1;
                  r_rx_state <= RX_IDLE;
               end
            default: r_rx_state <= RX_IDLE;
         endcase
         if (w_to_expire) r_rx_state <= RX_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state  <= TX_IDLE;
         r_resp_sent <= 1'b0;
      end else begin
         case (r_tx_state)
            TX_IDLE:
               if (snd_resp) begin
                  r_resp_sent <= 1'b0;
                  r_tx_state  <= TX_BUSY;
               end
            TX_BUSY:
               if (w_tx_done) begin
                  r_resp_sent <= 1'b1;
                  r_tx_state  <= TX_IDLE;
               end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   assign cmd       = r_cmd;
   assign data      = r_data;
   assign cmd_rdy   = r_cmd_rdy;
   assign resp_sent = r_resp_sent;

endmodule
